// File: rtl/m_estado.sv
// Free-running 8-state descending sequencer (7,6,...,0,7); Estados is the state register itself.
// One step per CLK edge, no stalls; synchronous active-low Re forces home state S7 on the same edge.
module m_estado (
  input  logic       CLK,
  input  logic       Re,
  output logic [2:0] Estados
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  // Register powers up in the home state so Estados is defined before the first edge.
  state_t state = S7;

  always_ff @(posedge CLK) begin
    if (!Re) begin
      state <= S7;
    end else begin
      case (state)
        S7:      state <= S6;
        S6:      state <= S5;
        S5:      state <= S4;
        S4:      state <= S3;
        S3:      state <= S2;
        S2:      state <= S1;
        S1:      state <= S0;
        S0:      state <= S7;
        default: state <= S7;
      endcase
    end
  end

  assign Estados = state;

endmodule

// File: tb/tb_m_estado.sv
// Scoreboard bench for m_estado: driver pushes the expected code per edge, monitor pops and compares.
module tb_m_estado;

  logic       clk;
  logic       re;
  logic [2:0] estados;

  int n_cmp  = 0;
  int n_fail = 0;
  int k      = 0;   // consecutive Re=1 edges since the last reset edge
  logic [2:0] exp_q[$];

  m_estado dut (
    .CLK     (clk),
    .Re      (re),
    .Estados (estados)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] model_code(input int steps);
    int v;
    v = (7 - steps) % 8;
    if (v < 0) v = v + 8;
    return v[2:0];
  endfunction

  // Set Re for the coming edge, record the expected result, optionally glitch Re mid-cycle.
  task automatic step(input bit r, input bit glitch);
    @(negedge clk);
    re = r;
    if (!r) k = 0;
    else    k = k + 1;
    exp_q.push_back(model_code(k));
    if (glitch) begin
      #1 re = ~r;
      #1 re = r;
    end
  endtask

  task automatic run(input int n, input bit r);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  // Monitor: the output is valid every cycle, so compare one entry after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (estados !== e) begin
        n_fail++;
        $display("FAIL seq t=%0t: Estados=%0d expected=%0d", $time, estados, e);
      end
    end
  end

  initial begin
    re = 1'b0;
    k  = 0;
    // Power-up value, before any edge.
    #1;
    n_cmp++;
    if (estados !== 3'd7) begin
      n_fail++;
      $display("FAIL powerup: Estados=%0d expected=7", estados);
    end
    exp_q.push_back(model_code(0));   // first edge at t=5 sees Re=0

    run(10, 1'b0);                    // reset hold
    run(8, 1'b1);                     // release and one full period
    run(1, 1'b0);
    run(20, 1'b1);                    // wrap-around twice
    run(1, 1'b0);
    run(2, 1'b1);                     // short run then reset
    run(3, 1'b0);
    run(7, 1'b1);                     // reach code 0
    run(1, 1'b0);                     // reset on the wrap edge
    run(1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);  // low glitches between edges
    run(1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);   // high glitches while held in reset
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m_estado.md
Name: m_estado

Overview:
- Free-running 8-state sequencer that steps once per rising edge of CLK.
- The 3-bit state code is exposed directly on Estados.
- Used as a small sequence/phase generator for downstream logic that decodes Estados.
- A synchronous, active-low reset (Re) returns the machine to its home state 7.

Parameters:
- None. State count (8) and encoding (3 bits) are fixed.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Re  input  1  synchronous reset, active-low; Re=0 at a rising edge forces the home state.
- Estados  output  3  current state code, driven directly from the state register.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. Clock port is CLK, reset port is Re.
- States: S7..S0, encoded as the unsigned binary value of the index (S7=3'b111 ... S0=3'b000).
- Estados is a registered output: it always equals the current state code, with no combinational path from Re.
- Home/reset state: S7, so Estados=3'd7.
- Reset: at any rising edge with Re=0, the next state is S7, regardless of the current state.
  - Re is sampled only on the clock edge; changes between edges have no effect.
  - Holding Re=0 for N edges keeps Estados=7 for all N edges.
- Run: at a rising edge with Re=1, the state advances one step in descending order: S7→S6→S5→S4→S3→S2→S1→S0→S7.
  - The S0→S7 transition is a wrap-around.
  - One transition per edge; no stalls, no skipped states. Full period is 8 cycles.
- Release latency: after the first edge with Re=1 following reset, Estados=6. After the k-th consecutive such edge, Estados=(7−k) mod 8.
- Reset mid-sequence: Re=0 at any edge, including the wrap edge from S0, yields Estados=7 on that edge. No partial or intermediate state is visible.
- Reset wins over all other activity; there is no other input.
- Power-up: the state register initialises to S7 (Estados=7), so the output is defined before the first clock edge.
- Illegal/unreachable codes: none exist, since all 8 codes are legal states.
- Implementation is an explicit FSM:
  - state register plus a next-state case statement covering all 8 states, with a default branch to S7;
  - a separate output assignment.
  - An arithmetic decrement alone is not acceptable; the state case structure must be present for later per-state decode extensions.

Test Plan:
- Reset hold: Re=0 for 10 rising edges → Estados=7 after every edge; also 7 at time 0 before any edge.
- Release and count: after reset, Re=1 for 8 edges → Estados sequence 6,5,4,3,2,1,0,7. Period confirmed as 8.
- Wrap-around: Re=1 continuously for 20 edges from reset → Estados after edge 8 is 7 and after edge 16 is 7. The pattern repeats exactly.
- Short run then reset: Re=1 for 2 edges (Estados 6, then 5), then Re=0 → Estados=7 at the next edge and stays 7 while Re=0.
- Reset at wrap point: run to Estados=0, then Re=0 on the next edge → Estados=7. Then Re=1 → Estados=6, confirming normal resumption.
- Asynchronous glitch immunity: pulse Re low between two rising edges, returning high before the next edge → no reset occurs and the sequence continues uninterrupted.
